// File: rtl/ncc_pkg.sv
// Shared constants and state encoding for the NCC search-window builder.
// Window positions follow from region and window size: one per valid top-left corner.
package ncc_pkg;

  localparam int WIN           = 16;
  localparam int REGION_W      = 30;
  localparam int REGION_H      = 25;
  localparam int COL_POSITIONS = REGION_W - WIN + 1;
  localparam int ROW_POSITIONS = REGION_H - WIN + 1;
  localparam int NUM_WINDOWS   = COL_POSITIONS * ROW_POSITIONS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    PRESENT = 2'd2,
    SHIFT   = 2'd3
  } wb_state_t;

endpackage

// File: rtl/window_row_buffer.sv
// WIN rows x REGION_W columns of pixel storage with a row write port, a one-cycle
// shift-up of all rows and a combinational WIN x WIN window mux at a column offset.
module window_row_buffer #(
  parameter int WIN      = ncc_pkg::WIN,
  parameter int REGION_W = ncc_pkg::REGION_W,
  parameter int RW       = $clog2(WIN),
  parameter int CW       = $clog2(REGION_W),
  parameter int OW       = $clog2(REGION_W - WIN + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [RW-1:0]                wr_row,
  input  logic [CW-1:0]                wr_col,
  input  logic [7:0]                   wr_data,
  input  logic                         shift_en,
  input  logic [OW-1:0]                col_off,
  output logic [WIN-1:0][WIN-1:0][7:0] window
);

  logic [REGION_W-1:0][7:0] mem [WIN];

  // Shift and write never coincide: shift fires on a consumer done, writes only while filling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIN; i++) mem[i] <= '0;
    end else if (shift_en) begin
      for (int i = 0; i < WIN - 1; i++) mem[i] <= mem[i+1];
    end else if (wr_en) begin
      mem[wr_row][wr_col] <= wr_data;
    end
  end

  always_comb begin
    for (int i = 0; i < WIN; i++) begin
      for (int j = 0; j < WIN; j++) begin
        window[i][j] = mem[i][CW'(col_off) + CW'(j)];
      end
    end
  end

endmodule

// File: rtl/window_builder.sv
// Streams a raster search region into a WIN-row buffer and presents every WIN x WIN
// window in row-major order. pix_valid/pix_ready and window_data_ready/done_with_window_data
// are valid/ready style: a pixel moves on a clock edge where both pix_valid and pix_ready are
// high; a window is retired on an edge where window_data_ready and done_with_window_data are high.
module window_builder #(
  parameter int REGION_W = ncc_pkg::REGION_W,
  parameter int REGION_H = ncc_pkg::REGION_H,
  parameter int WIN      = ncc_pkg::WIN
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         region_start,
  input  logic [7:0]                   pix_in,
  input  logic                         pix_valid,
  output logic                         pix_ready,
  output logic [WIN-1:0][WIN-1:0][7:0] window_data_out,
  output logic                         window_data_ready,
  input  logic                         done_with_window_data,
  output logic [8:0]                   window_index,
  output logic                         region_done,
  output logic                         busy,
  output ncc_pkg::wb_state_t           dbg_state
);
  import ncc_pkg::*;

  localparam int COL_POS = REGION_W - WIN + 1;
  localparam int ROW_POS = REGION_H - WIN + 1;
  localparam int RW      = $clog2(WIN);
  localparam int CW      = $clog2(REGION_W);
  localparam int OW      = $clog2(COL_POS);
  localparam int ROW_OW  = $clog2(ROW_POS);

  localparam logic [RW-1:0]     ROW_MAX  = RW'(WIN - 1);
  localparam logic [CW-1:0]     COL_MAX  = CW'(REGION_W - 1);
  localparam logic [OW-1:0]     COL_LAST = OW'(COL_POS - 1);
  localparam logic [ROW_OW-1:0] ROW_LAST = ROW_OW'(ROW_POS - 1);

  wb_state_t         state, state_nx;
  logic [RW-1:0]     row_cnt, row_cnt_nx;
  logic [CW-1:0]     col_cnt, col_cnt_nx;
  logic [OW-1:0]     col_off, col_off_nx;
  logic [ROW_OW-1:0] row_off, row_off_nx;
  logic              wdr_nx, rdone_nx, shift_en, accept;

  assign pix_ready    = (state == FILL) || (state == SHIFT);
  assign accept       = pix_ready && pix_valid;
  assign busy         = (state != IDLE);
  assign dbg_state    = state;
  assign window_index = 9'(row_off) * 9'(COL_POS) + 9'(col_off);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      row_cnt           <= '0;
      col_cnt           <= '0;
      col_off           <= '0;
      row_off           <= '0;
      window_data_ready <= 1'b0;
      region_done       <= 1'b0;
    end else begin
      state             <= state_nx;
      row_cnt           <= row_cnt_nx;
      col_cnt           <= col_cnt_nx;
      col_off           <= col_off_nx;
      row_off           <= row_off_nx;
      window_data_ready <= wdr_nx;
      region_done       <= rdone_nx;
    end
  end

  // row_cnt parks at the bottom row after the fill, so SHIFT refills that row with the same port.
  always_comb begin
    state_nx   = state;
    row_cnt_nx = row_cnt;
    col_cnt_nx = col_cnt;
    col_off_nx = col_off;
    row_off_nx = row_off;
    wdr_nx     = 1'b0;
    rdone_nx   = 1'b0;
    shift_en   = 1'b0;
    case (state)
      IDLE: begin
        if (region_start) begin
          state_nx   = FILL;
          row_cnt_nx = '0;
          col_cnt_nx = '0;
          col_off_nx = '0;
          row_off_nx = '0;
        end
      end
      FILL: begin
        if (accept) begin
          if (col_cnt == COL_MAX) begin
            col_cnt_nx = '0;
            if (row_cnt == ROW_MAX) begin
              state_nx = PRESENT;
              wdr_nx   = 1'b1;
            end else begin
              row_cnt_nx = row_cnt + 1'b1;
            end
          end else begin
            col_cnt_nx = col_cnt + 1'b1;
          end
        end
      end
      PRESENT: begin
        wdr_nx = 1'b1;
        if (window_data_ready && done_with_window_data) begin
          wdr_nx = 1'b0;
          if (col_off != COL_LAST) begin
            col_off_nx = col_off + 1'b1;
          end else if (row_off != ROW_LAST) begin
            col_off_nx = '0;
            row_off_nx = row_off + 1'b1;
            shift_en   = 1'b1;
            state_nx   = SHIFT;
          end else begin
            rdone_nx = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      SHIFT: begin
        if (accept) begin
          if (col_cnt == COL_MAX) begin
            col_cnt_nx = '0;
            state_nx   = PRESENT;
            wdr_nx     = 1'b1;
          end else begin
            col_cnt_nx = col_cnt + 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  window_row_buffer #(
    .WIN      (WIN),
    .REGION_W (REGION_W)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (accept),
    .wr_row   (row_cnt),
    .wr_col   (col_cnt),
    .wr_data  (pix_in),
    .shift_en (shift_en),
    .col_off  (col_off),
    .window   (window_data_out)
  );

endmodule

// File: doc/window_builder.md
WINDOW_BUILDER -- requirements
Module: window_builder

Interface
REQ-001 Parameters SHALL be: REGION_W 30, search-region width in pixels; REGION_H 25, search-region height in pixels; WIN 16, window edge in pixels.
REQ-002 clk  input  1  clock, rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 region_start  input  1  one-cycle pulse that begins a new search region.
REQ-005 pix_in  input  8  region pixel, raster order (row-major).
REQ-006 pix_valid  input  1  pix_in is valid.
REQ-007 pix_ready  output  1  block accepts pix_in this cycle.
REQ-008 window_data_out  output  8 x [15:0][15:0]  current window; element [i][j] = region pixel (row_off+i, col_off+j).
REQ-009 window_data_ready  output  1  window_data_out is valid and held.
REQ-010 done_with_window_data  input  1  consumer has captured the current window (one-cycle pulse).
REQ-011 window_index  output  9  index of the presented window, row_off*15+col_off.
REQ-012 region_done  output  1  one-cycle pulse after the consumer completes the final window.
REQ-013 busy  output  1  high from region_start acceptance until region_done.

Function
REQ-014 The FSM SHALL have four states: IDLE, FILL, PRESENT and SHIFT.
REQ-015 IDLE: region_start -> FILL; clear row counter, column counter, col_off and row_off.
REQ-016 FILL: pix_ready=1; pixel accepted when pix_valid&pix_ready, written to buf[row_cnt][col_cnt]; col_cnt wraps 29->0 and increments row_cnt; after 480th pixel (row 15 col 29) -> PRESENT next cycle.
REQ-017 PRESENT: pix_ready=0; window_data_ready=1 and window_data_out/window_index stable until done_with_window_data seen.
REQ-018 On a done_with_window_data edge, window_data_ready SHALL be 0 in the following cycle (exactly one low cycle before the next window).
REQ-019 After done, if col_off<14: col_off++ and stay in PRESENT.
REQ-020 After done, if col_off==14 and row_off<9: col_off=0, row_off++; shift rows up (buf[i]<=buf[i+1], i=0..14) in one cycle; -> SHIFT.
REQ-021 After done, if col_off==14 and row_off==9: pulse region_done; -> IDLE.
REQ-022 SHIFT: pix_ready=1; 30 accepted pixels are written to buf[15][0..29]; after the 30th -> PRESENT.
REQ-023 Exactly 150 windows SHALL be produced per region, in row-major order; window_index SHALL match the consumer's internal window count.
REQ-024 region_start outside IDLE SHALL be ignored.
REQ-025 done_with_window_data outside PRESENT or while window_data_ready=0 SHALL be ignored.
REQ-026 pix_valid with pix_ready=0 SHALL NOT be consumed; no pixel is dropped or duplicated.
REQ-027 Gaps in pix_valid SHALL stall the counters without corrupting data.
REQ-028 The window mux SHALL be combinational from buf and col_off; row_off SHALL affect only window_index.

Reset
REQ-029 On rst: state=IDLE; all counters 0; pix_ready=0; window_data_ready=0; region_done=0; busy=0; window_index=0; buf contents zero.
REQ-030 rst mid-FILL, mid-SHIFT or mid-PRESENT SHALL abandon the region; the next region_start SHALL restart from pixel (0,0).

Structure
REQ-031 Package ncc_pkg SHALL hold WIN, REGION_W, REGION_H, NUM_WINDOWS=150, COL_POSITIONS=15, ROW_POSITIONS=10 and the window-builder state enum.
REQ-032 One sub-module, window_row_buffer, SHALL be used: 16x30x8 storage with row write port, shift-up control and column-offset window mux.

Verification
Stimulus for all scenarios, unless stated otherwise: pixel(r,c) = (r*30+c) mod 256.
REQ-033 Full region with the consumer capturing each window with 1-cycle done latency -> window 0: [0][0]=0, [15][15]=209; window 14: [0][0]=14; window 15: [0][0]=30, index 15; window 149: [0][0]=28, [15][15]=237, index 149; region_done 1 cycle after the final done.
REQ-034 pix_valid toggling 1/0 every cycle -> identical windows to REQ-033; pix_ready=0 throughout PRESENT.
REQ-035 done_with_window_data delayed 20 cycles on window 7 -> window_data_out and index 7 held constant for the full 20 cycles.
REQ-036 rst asserted after 250 FILL pixels, then region_start -> all outputs at reset values; first window [0][0]=0.
REQ-037 region_start pulsed during PRESENT and a spurious done during FILL -> no state, counter or output change.
REQ-038 Two back-to-back regions -> 300 window_data_ready handshakes, two region_done pulses, busy low for at least 1 cycle between regions.
